univ_reg_pr: RTL and testbench
==============================

Name: univ_reg_pr

Overview:
- Parametrised successor to the single-bit preset/clear D flip-flop: a WIDTH-bit register with synchronous clear and preset.
- Eight operating modes: hold, parallel load, logical shift left/right, count up/down, rotate left/right.
- Registered carry/shift-out flag for cascading.
- Used as the general storage, counter and shift element for datapath labs built on the flip-flop library.

Parameters:
WIDTH, 8, register width in bits (>= 2)
PRESET_VAL, {WIDTH{1'b1}}, value loaded by PRE

Ports:
clk  input  1  rising-edge clock
CLR  input  1  synchronous active-high reset/clear
PRE  input  1  synchronous active-high preset
en  input  1  operation enable; 0 = hold
mode  input  3  operation select (see Behaviour)
D  input  WIDTH  parallel load data
SI_L  input  1  serial in for shift left (enters bit 0)
SI_R  input  1  serial in for shift right (enters bit WIDTH-1)
Q  output  WIDTH  register value
QB  output  WIDTH  bitwise complement of Q, always ~Q (combinational)
CO  output  1  registered carry/shift-out flag

Behaviour:
- Single clock domain. All state changes occur on the rising edge of clk; no asynchronous paths.
- Reset: CLR=1 at an edge -> Q=0, QB=all ones, CO=0 after that edge.
- Priority per edge: CLR > PRE > en=0 > mode.
- CLR and PRE both high -> clear wins: Q=0, CO=0.
- PRE=1 (CLR=0) -> Q=PRESET_VAL, CO=0.
- en=0 -> Q holds, CO<=0.
- en=1, mode:
  - 000 hold: Q holds, CO<=0.
  - 001 load: Q<=D, CO<=0.
  - 010 shl: Q<={Q[WIDTH-2:0],SI_L}, CO<=old Q[WIDTH-1].
  - 011 shr: Q<={SI_R,Q[WIDTH-1:1]}, CO<=old Q[0].
  - 100 up: Q<=Q+1 mod 2^WIDTH; CO<=1 iff old Q == all ones (wrap to 0).
  - 101 down: Q<=Q-1 mod 2^WIDTH; CO<=1 iff old Q == 0 (wrap to all ones).
  - 110 rol: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}, CO<=old Q[WIDTH-1].
  - 111 ror: Q<={Q[0],Q[WIDTH-1:1]}, CO<=old Q[0].
- CO is a one-cycle pulse aligned with the Q value produced by the same edge. It is never sticky; every edge rewrites it.
- Latency: one edge for every operation. Q reflects the operation at the edge where the command is sampled.
- Mid-operation CLR: the current count or shift sequence is abandoned. The next cycle resumes from 0 using whatever mode is then applied.
- X on mode while en=1 is an error; a bench assertion flags it (not required in RTL).
- Arithmetic is unsigned WIDTH-bit with natural wrap; no saturation.

Decomposition:
- Shared package univ_reg_pkg:
  - typedef enum logic [2:0] mode_t: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_UP, MODE_DOWN, MODE_ROL, MODE_ROR.
  - Used by RTL and bench.
- Sub-module dff_sync_pr:
  - One-bit D flip-flop with synchronous CLR/PRE (CLR priority), outputs Q/QB.
  - Instantiated WIDTH times via generate. Each instance's PRE is gated so that it applies PRESET_VAL[i].
  - Next-state mux logic lives in univ_reg_pr.
- The CO flop is a separate dff_sync_pr instance with PRE tied 0.

Test Plan:
- WIDTH=4. CLR=1 one edge -> Q=0000, QB=1111, CO=0. Then PRE=1 -> Q=1111. CLR=1,PRE=1 together -> Q=0000.
- Load D=1010 (mode 001) -> Q=1010. Then en=0 with mode 100 for 3 edges -> Q stays 1010, CO=0.
- Load 1101, mode 100 for 3 edges -> Q=1110, 1111, 0000. CO=1 only on the edge producing 0000. Then mode 101 from 0000 -> Q=1111, CO=1.
- Load 1001, mode 010 with SI_L=0 -> Q=0010, CO=1. Then mode 011 with SI_R=1 -> Q=1001, CO=0.
- Load 1000, mode 110 four edges -> 0001 (CO=1), 0010, 0100, 1000. Then mode 111 one edge -> 0100, CO=0.
- Count up from 0110 for 2 edges, assert CLR on the 3rd edge while mode=100 -> Q=0000, CO=0. Next edge with mode=100 -> Q=0001.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - shared mode encoding for the universal preset/clear register
package univ_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_UP   = 3'b100,
    MODE_DOWN = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_ROR  = 3'b111
  } mode_t;

endpackage

// File: rtl/univ_reg_pr_if.sv
// rtl/univ_reg_pr_if.sv - control, data and status bundle of univ_reg_pr
import univ_reg_pkg::*;

interface univ_reg_pr_if #(
  parameter int WIDTH = 8
);
  logic             PRE;
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] D;
  logic             SI_L;
  logic             SI_R;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QB;
  logic             CO;

  modport master (
    output PRE, en, mode, D, SI_L, SI_R,
    input  Q, QB, CO
  );

  modport slave (
    input  PRE, en, mode, D, SI_L, SI_R,
    output Q, QB, CO
  );
endinterface

// File: rtl/dff_sync_pr.sv
// rtl/dff_sync_pr.sv - one-bit D flip-flop with synchronous clear/preset, clear wins
module dff_sync_pr (
  input  logic clk,
  input  logic CLR,
  input  logic PRE,
  input  logic D,
  output logic Q,
  output logic QB
);

  always_ff @(posedge clk) begin
    if (CLR)
      Q <= 1'b0;
    else if (PRE)
      Q <= 1'b1;
    else
      Q <= D;
  end

  assign QB = ~Q;

endmodule

// File: rtl/univ_reg_pr.sv
// rtl/univ_reg_pr.sv - WIDTH-bit hold/load/shift/count/rotate register built from dff_sync_pr
import univ_reg_pkg::*;

module univ_reg_pr #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input logic           clk,
  input logic           CLR,
  univ_reg_pr_if.slave  bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] q_nxt;
  logic             co_nxt;
  logic             co_q;

  always_comb begin
    q_nxt  = q;
    co_nxt = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: q_nxt = q;
        MODE_LOAD: q_nxt = bus.D;
        MODE_SHL: begin
          q_nxt  = {q[WIDTH-2:0], bus.SI_L};
          co_nxt = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_nxt  = {bus.SI_R, q[WIDTH-1:1]};
          co_nxt = q[0];
        end
        MODE_UP: begin
          q_nxt  = q + 1'b1;
          co_nxt = &q;
        end
        MODE_DOWN: begin
          q_nxt  = q - 1'b1;
          co_nxt = ~|q;
        end
        MODE_ROL: begin
          q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
          co_nxt = q[WIDTH-1];
        end
        MODE_ROR: begin
          q_nxt  = {q[0], q[WIDTH-1:1]};
          co_nxt = q[0];
        end
        default: q_nxt = q;
      endcase
    end
  end

  // A preset of a bit whose PRESET_VAL is 0 is realised as a clear of that bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_clr;
    logic bit_pre;
    assign bit_clr = CLR | (bus.PRE & ~PRESET_VAL[i]);
    assign bit_pre = bus.PRE & PRESET_VAL[i];

    dff_sync_pr u_dff (
      .clk (clk),
      .CLR (bit_clr),
      .PRE (bit_pre),
      .D   (q_nxt[i]),
      .Q   (q[i]),
      .QB  (qb[i])
    );
  end

  // Carry flag is also forced low on preset, so it shares the clear path.
  dff_sync_pr u_co (
    .clk (clk),
    .CLR (CLR | bus.PRE),
    .PRE (1'b0),
    .D   (co_nxt),
    .Q   (co_q),
    .QB  ()
  );

  assign bus.Q  = q;
  assign bus.QB = qb;
  assign bus.CO = co_q;

endmodule

// File: tb/tb_univ_reg_pr.sv
// tb/tb_univ_reg_pr.sv - directed plus randomized check of univ_reg_pr against an arithmetic model
import univ_reg_pkg::*;

module tb_univ_reg_pr;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic CLR;
  int   n_vec = 0;
  int   n_bad = 0;
  int   mq = 0;
  int   mco = 0;

  always #5 clk = ~clk;

  univ_reg_pr_if #(.WIDTH(W)) bus ();

  univ_reg_pr #(.WIDTH(W)) dut (
    .clk (clk),
    .CLR (CLR),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (bus.en === 1'b1)
      assert (!$isunknown(bus.mode)) else $error("mode is X while en=1");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int clr, input int pre, input int en, input int m,
                       input int d, input int sil, input int sir);
    int q;
    q = mq;
    mco = 0;
    if (clr != 0) mq = 0;
    else if (pre != 0) mq = M - 1;
    else if (en != 0) begin
      case (m)
        1: mq = d;
        2: begin mq = (q * 2 + sil) % M;        mco = q / (M / 2); end
        3: begin mq = sir * (M / 2) + q / 2;    mco = q % 2; end
        4: begin mq = (q + 1) % M;              mco = (q == M - 1); end
        5: begin mq = (q + M - 1) % M;          mco = (q == 0); end
        6: begin mq = (q * 2 + q / (M / 2)) % M; mco = q / (M / 2); end
        7: begin mq = (q % 2) * (M / 2) + q / 2; mco = q % 2; end
        default: mq = q;
      endcase
    end
  endtask

  task automatic step(input string tag, input int clr, input int pre, input int en,
                      input int m, input int d, input int sil, input int sir);
    CLR      = clr[0];
    bus.PRE  = pre[0];
    bus.en   = en[0];
    bus.mode = mode_t'(m[2:0]);
    bus.D    = d[W-1:0];
    bus.SI_L = sil[0];
    bus.SI_R = sir[0];
    @(posedge clk);
    #1;
    model(clr, pre, en, m, d, sil, sir);
    chk({tag, ".Q"},  32'(bus.Q),  32'(mq));
    chk({tag, ".QB"}, 32'(bus.QB), 32'((~mq) & (M - 1)));
    chk({tag, ".CO"}, 32'(bus.CO), 32'(mco));
  endtask

  initial begin
    CLR = 1'b0; bus.PRE = 1'b0; bus.en = 1'b0; bus.mode = MODE_HOLD;
    bus.D = '0; bus.SI_L = 1'b0; bus.SI_R = 1'b0;

    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("preset", 0, 1, 0, 0, 0, 0, 0);
    step("clr_pre", 1, 1, 1, 4, 0, 0, 0);

    step("load_a", 0, 0, 1, 1, 4'b1010, 0, 0);
    for (int i = 0; i < 3; i++) step("en0_hold", 0, 0, 0, 4, 0, 0, 0);

    step("load_d", 0, 0, 1, 1, 4'b1101, 0, 0);
    for (int i = 0; i < 3; i++) step("up", 0, 0, 1, 4, 0, 0, 0);
    step("down_wrap", 0, 0, 1, 5, 0, 0, 0);

    step("load_9", 0, 0, 1, 1, 4'b1001, 0, 0);
    step("shl", 0, 0, 1, 2, 0, 0, 0);
    step("shr", 0, 0, 1, 3, 0, 0, 1);

    step("load_8", 0, 0, 1, 1, 4'b1000, 0, 0);
    for (int i = 0; i < 4; i++) step("rol", 0, 0, 1, 6, 0, 0, 0);
    step("ror", 0, 0, 1, 7, 0, 0, 0);

    step("load_6", 0, 0, 1, 1, 4'b0110, 0, 0);
    step("up_a", 0, 0, 1, 4, 0, 0, 0);
    step("up_b", 0, 0, 1, 4, 0, 0, 0);
    step("mid_clr", 1, 0, 1, 4, 0, 0, 0);
    step("resume", 0, 0, 1, 4, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 7) != 0) ? 1 : 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
